// File: rtl/uart_pkg.sv
// Shared UART types: parity mode, receiver states and the packed frame entry.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4,
    RX_BRKWT  = 3'd5
  } rx_state_t;

  localparam int PAYLOAD_MAX = 9;

  typedef struct packed {
    logic                   brk;
    logic                   frm;
    logic                   par;
    logic [PAYLOAD_MAX-1:0] data;
  } rx_entry_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO; when empty the output holds the last popped word.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_overrun
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic [WIDTH-1:0] r_hold;
  logic             r_ovr;
  logic             w_pop;
  logic             w_wr;

  assign o_empty   = (r_level == '0);
  assign o_full    = (r_level == LW'(DEPTH));
  assign w_pop     = i_pop & ~o_empty;
  // a full FIFO still accepts a push when the same cycle frees a slot
  assign w_wr      = i_push & (~o_full | w_pop);
  assign o_data    = o_empty ? r_hold : r_mem[r_rd_ptr];
  assign o_level   = r_level;
  assign o_overrun = r_ovr;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_hold   <= '0;
      r_ovr    <= 1'b0;
    end else begin
      r_ovr <= i_push & o_full & ~w_pop;
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_hold   <= r_mem[r_rd_ptr];
      end
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with majority-vote bit decisions, per-frame status and frame FIFO.
//  state     | meaning
//  RX_IDLE   | waiting for a falling edge on the synced line
//  RX_START  | validating the start bit at mid-sample
//  RX_DATA   | shifting payload bits LSB first
//  RX_PARITY | checking the parity bit
//  RX_STOP   | checking stop bits, frame pushed after the last
//  RX_BRKWT  | line held low after a BREAK, waiting for idle
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int      CLK_HZ       = 50_000_000,
  parameter int      BIT_RATE     = 115_200,
  parameter int      OVERSAMPLE   = 16,
  parameter int      PAYLOAD_BITS = 8,
  parameter int      STOP_BITS    = 1,
  parameter parity_t PARITY       = PAR_NONE,
  parameter int      FIFO_DEPTH   = 4
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            uart_rxd,
  input  logic                            uart_rx_en,
  output logic [PAYLOAD_BITS-1:0]         rx_data,
  output logic                            rx_parity_err,
  output logic                            rx_frame_err,
  output logic                            rx_break,
  output logic                            rx_valid,
  input  logic                            rx_ready,
  output logic                            rx_overrun,
  output logic [$clog2(FIFO_DEPTH):0]     rx_level
);
  localparam int DIV = CLK_HZ / (BIT_RATE * OVERSAMPLE);
  localparam int MID = OVERSAMPLE / 2;
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int EW  = PAYLOAD_BITS + 3;

  if (DIV < 1) begin : g_div_check
    $error("uart_rx_fifo: CLK_HZ too low for BIT_RATE*OVERSAMPLE");
  end

  rx_state_t         r_state, w_next;
  logic              r_sync1, r_sync2, r_rxd_q;
  logic [DW-1:0]     r_div_cnt;
  logic [SW-1:0]     r_smp_cnt;
  logic [3:0]        r_bit_cnt;
  logic              r_s0, r_s1;
  logic [PAYLOAD_BITS-1:0] r_shift;
  logic              r_par_err, r_frm_err, r_par_bit, r_stop_low;
  logic              r_push;
  logic [EW-1:0]     r_entry;

  logic w_tick, w_mid, w_bit, w_fall, w_last_data, w_last_stop;
  logic w_exp_par, w_brk, w_frm;
  logic w_start, w_shift_en, w_par_en, w_stop_en, w_done;
  logic w_empty, w_full;
  logic [EW-1:0] w_head;

  assign w_tick      = (r_state != RX_IDLE) && (r_div_cnt == DW'(DIV - 1));
  assign w_mid       = w_tick && (r_smp_cnt == SW'(MID + 1));
  assign w_bit       = majority3(r_s0, r_s1, r_sync2);
  assign w_fall      = r_rxd_q & ~r_sync2;
  assign w_last_data = (r_bit_cnt == 4'(PAYLOAD_BITS - 1));
  assign w_last_stop = (r_bit_cnt == 4'(STOP_BITS - 1));
  assign w_exp_par   = (PARITY == PAR_EVEN) ? ^r_shift : ~^r_shift;
  assign w_frm       = r_frm_err | ~w_bit;
  assign w_brk       = (r_shift == '0) && !r_par_bit && r_stop_low && !w_bit;

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= RX_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (!uart_rx_en) begin
      w_next = RX_IDLE;
    end else begin
      case (r_state)
        RX_IDLE:   if (w_fall) w_next = RX_START;
        RX_START:  if (w_mid) w_next = w_bit ? RX_IDLE : RX_DATA;
        RX_DATA:   if (w_mid && w_last_data) w_next = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
        RX_PARITY: if (w_mid) w_next = RX_STOP;
        RX_STOP:   if (w_mid && w_last_stop) w_next = w_brk ? RX_BRKWT : RX_IDLE;
        RX_BRKWT:  if (r_sync2) w_next = RX_IDLE;
        default:   w_next = RX_IDLE;
      endcase
    end
  end

  always_comb begin
    w_start    = 1'b0;
    w_shift_en = 1'b0;
    w_par_en   = 1'b0;
    w_stop_en  = 1'b0;
    if (uart_rx_en) begin
      w_start    = (r_state == RX_IDLE) && w_fall;
      w_shift_en = (r_state == RX_DATA) && w_mid;
      w_par_en   = (r_state == RX_PARITY) && w_mid;
      w_stop_en  = (r_state == RX_STOP) && w_mid;
    end
    w_done = w_stop_en && w_last_stop;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_rxd_q    <= 1'b1;
      r_div_cnt  <= '0;
      r_smp_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_s0       <= 1'b1;
      r_s1       <= 1'b1;
      r_shift    <= '0;
      r_par_err  <= 1'b0;
      r_frm_err  <= 1'b0;
      r_par_bit  <= 1'b0;
      r_stop_low <= 1'b1;
      r_push     <= 1'b0;
      r_entry    <= '0;
    end else begin
      r_sync1 <= uart_rxd;
      r_sync2 <= r_sync1;
      r_rxd_q <= r_sync2;
      // divider and sample phase stay parked at 0 while idle so each frame starts aligned
      if (r_state == RX_IDLE) begin
        r_div_cnt <= '0;
        r_smp_cnt <= '0;
      end else if (w_tick) begin
        r_div_cnt <= '0;
        r_smp_cnt <= (r_smp_cnt == SW'(OVERSAMPLE - 1)) ? '0 : r_smp_cnt + SW'(1);
      end else begin
        r_div_cnt <= r_div_cnt + DW'(1);
      end
      if (w_tick && r_smp_cnt == SW'(MID - 1)) r_s0 <= r_sync2;
      if (w_tick && r_smp_cnt == SW'(MID))     r_s1 <= r_sync2;
      if (w_start) begin
        r_bit_cnt  <= '0;
        r_par_err  <= 1'b0;
        r_frm_err  <= 1'b0;
        r_par_bit  <= 1'b0;
        r_stop_low <= 1'b1;
      end
      if (w_shift_en) begin
        r_shift   <= {w_bit, r_shift[PAYLOAD_BITS-1:1]};
        r_bit_cnt <= w_last_data ? 4'd0 : r_bit_cnt + 4'd1;
      end
      if (w_par_en) begin
        r_par_err <= (w_bit != w_exp_par);
        r_par_bit <= w_bit;
      end
      if (w_stop_en) begin
        r_frm_err  <= w_frm;
        r_stop_low <= r_stop_low & ~w_bit;
        r_bit_cnt  <= w_last_stop ? 4'd0 : r_bit_cnt + 4'd1;
      end
      r_push <= w_done;
      if (w_done) r_entry <= {w_brk, w_frm, r_par_err, r_shift};
    end
  end

  uart_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .i_push    (r_push),
    .i_data    (r_entry),
    .i_pop     (rx_ready),
    .o_data    (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_level   (rx_level),
    .o_overrun (rx_overrun)
  );

  assign rx_data       = w_head[PAYLOAD_BITS-1:0];
  assign rx_parity_err = w_head[PAYLOAD_BITS];
  assign rx_frame_err  = w_head[PAYLOAD_BITS+1];
  assign rx_break      = w_head[PAYLOAD_BITS+2];
  assign rx_valid      = ~w_empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: even, odd and no-parity receivers on a shared stimulus line.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DIV     = 27;
  localparam int OS      = 16;
  localparam int BIT_CLK = DIV * OS;
  // cycle of the stop-bit mid-sample for a parity frame: 2 sync flops + edge register, then ticks
  localparam int LAT_MID = 3 + (DIV - 1) + DIV * (OS * 10 + OS / 2 + 1);

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic line = 1'b1;
  logic en = 1'b1;
  int   sel = 0;
  always #5 clk = ~clk;

  logic rxd_e, rxd_o, rxd_n;
  assign rxd_e = (sel == 0) ? line : 1'b1;
  assign rxd_o = (sel == 1) ? line : 1'b1;
  assign rxd_n = (sel == 2) ? line : 1'b1;

  logic ready_e = 1'b1, ready_o = 1'b1, ready_n = 1'b1;
  logic [7:0] data_e, data_o, data_n;
  logic par_e, par_o, par_n, frm_e, frm_o, frm_n, brk_e, brk_o, brk_n;
  logic valid_e, valid_o, valid_n, ovr_e, ovr_o, ovr_n;
  logic [2:0] level_e, level_o, level_n;

  uart_rx_fifo #(.PARITY(PAR_EVEN)) u_even (
    .clk(clk), .resetn(resetn), .uart_rxd(rxd_e), .uart_rx_en(en),
    .rx_data(data_e), .rx_parity_err(par_e), .rx_frame_err(frm_e), .rx_break(brk_e),
    .rx_valid(valid_e), .rx_ready(ready_e), .rx_overrun(ovr_e), .rx_level(level_e));
  uart_rx_fifo #(.PARITY(PAR_ODD)) u_odd (
    .clk(clk), .resetn(resetn), .uart_rxd(rxd_o), .uart_rx_en(en),
    .rx_data(data_o), .rx_parity_err(par_o), .rx_frame_err(frm_o), .rx_break(brk_o),
    .rx_valid(valid_o), .rx_ready(ready_o), .rx_overrun(ovr_o), .rx_level(level_o));
  uart_rx_fifo #(.PARITY(PAR_NONE)) u_none (
    .clk(clk), .resetn(resetn), .uart_rxd(rxd_n), .uart_rx_en(en),
    .rx_data(data_n), .rx_parity_err(par_n), .rx_frame_err(frm_n), .rx_break(brk_n),
    .rx_valid(valid_n), .rx_ready(ready_n), .rx_overrun(ovr_n), .rx_level(level_n));

  int n_checks = 0;
  int n_errors = 0;
  int n_pops = 0;
  int n_ovr = 0;
  rx_entry_t sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic mon_pop(input string tag, input rx_entry_t got);
    rx_entry_t e;
    n_pops++;
    if (sb.size() == 0) begin
      chk({tag, "_unexpected"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk(tag, 32'(got), 32'(e));
    end
  endtask

  always @(negedge clk) begin
    if (resetn && valid_e && ready_e) mon_pop("even_entry", rx_entry_t'({brk_e, frm_e, par_e, 1'b0, data_e}));
    if (resetn && valid_o && ready_o) mon_pop("odd_entry", rx_entry_t'({brk_o, frm_o, par_o, 1'b0, data_o}));
    if (resetn && valid_n && ready_n) mon_pop("none_entry", rx_entry_t'({brk_n, frm_n, par_n, 1'b0, data_n}));
    if (ovr_e | ovr_o | ovr_n) n_ovr++;
  end

  function automatic rx_entry_t model(input parity_t mode, input logic [7:0] d, input logic pbit,
                                      input logic stopv);
    rx_entry_t e;
    e.data = {1'b0, d};
    e.frm  = ~stopv;
    e.par  = (mode == PAR_NONE) ? 1'b0 : (pbit != ((mode == PAR_EVEN) ? ^d : ~^d));
    e.brk  = (d == 8'h00) && ((mode == PAR_NONE) || !pbit) && !stopv;
    return e;
  endfunction

  task automatic send_bit(input logic v);
    @(posedge clk);
    #1 line = v;
    repeat (BIT_CLK - 1) @(posedge clk);
  endtask

  task automatic send_frame(input int s, input logic [7:0] d, input logic pbit, input logic stopv,
                            input bit expect_push);
    parity_t mode;
    mode = (s == 0) ? PAR_EVEN : (s == 1) ? PAR_ODD : PAR_NONE;
    sel = s;
    if (expect_push) sb.push_back(model(mode, d, pbit, stopv));
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (mode != PAR_NONE) send_bit(pbit);
    send_bit(stopv);
    if (!stopv) send_bit(1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, p0, o0, t;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid_e", 32'(valid_e), 32'd0);
    chk("rst_level_e", 32'(level_e), 32'd0);
    chk("rst_data_o", 32'(data_o), 32'd0);
    chk("rst_flags_n", 32'({brk_n, frm_n, par_n}), 32'd0);
    chk("rst_overrun_n", 32'(ovr_n), 32'd0);
    @(posedge clk);
    #1 resetn = 1'b1;
    repeat (10) @(posedge clk);

    // 1: even parity, clean frame, latency from stop mid-sample to rx_valid
    p0 = n_pops;
    n = 0;
    fork
      send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b1);
      begin
        @(posedge clk);
        @(negedge clk);
        while (!valid_e && n < 6000) begin
          @(posedge clk);
          n++;
          @(negedge clk);
        end
      end
    join
    chk("t1_valid_latency_ok", 32'((n >= LAT_MID + 1) && (n <= LAT_MID + 2)), 32'd1);
    chk("t1_entries", 32'(n_pops - p0), 32'd1);

    // 2: odd parity, wrong then right parity bit
    send_frame(1, 8'h3C, 1'b0, 1'b1, 1'b1);
    send_frame(1, 8'h3C, 1'b1, 1'b1, 1'b1);
    send_frame(1, 8'h81, 1'b1, 1'b1, 1'b1);

    // 3: no parity, zero stop bit
    send_frame(2, 8'h55, 1'b0, 1'b0, 1'b1);
    chk("t3_sb_empty", 32'(sb.size()), 32'd0);

    // 4: BREAK of 12 bit times
    p0 = n_pops;
    sel = 2;
    sb.push_back(model(PAR_NONE, 8'h00, 1'b0, 1'b0));
    repeat (12) send_bit(1'b0);
    repeat (3) send_bit(1'b1);
    chk("t4_entries", 32'(n_pops - p0), 32'd1);
    chk("t4_valid_after", 32'(valid_n), 32'd0);

    // 5: overrun with consumer stalled
    ready_n = 1'b0;
    o0 = n_ovr;
    p0 = n_pops;
    for (int v = 1; v <= 5; v++) send_frame(2, 8'(v), 1'b0, 1'b1, v <= 4);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("t5_level", 32'(level_n), 32'd4);
    chk("t5_overrun_pulses", 32'(n_ovr - o0), 32'd1);
    chk("t5_head", 32'(data_n), 32'h01);
    @(posedge clk);
    #1 ready_n = 1'b1;
    t = 0;
    while (level_n != 3'd0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    @(negedge clk);
    chk("t5_drained", 32'(level_n), 32'd0);
    chk("t5_pops", 32'(n_pops - p0), 32'd4);
    chk("t5_sb_empty", 32'(sb.size()), 32'd0);

    // 6a: short low glitch
    p0 = n_pops;
    sel = 2;
    @(posedge clk);
    #1 line = 1'b0;
    repeat (5 * DIV) @(posedge clk);
    #1 line = 1'b1;
    repeat (2 * BIT_CLK) @(posedge clk);
    @(negedge clk);
    chk("t6_glitch_valid", 32'(valid_n), 32'd0);
    chk("t6_glitch_pops", 32'(n_pops - p0), 32'd0);

    // 6b: reset in the middle of data bit 3 with one entry already buffered
    ready_n = 1'b0;
    send_frame(2, 8'h11, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("t6_pre_reset_level", 32'(level_n), 32'd1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    @(posedge clk);
    #1 line = 1'b1;
    repeat (BIT_CLK / 2) @(posedge clk);
    #1 resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t6_reset_level", 32'(level_n), 32'd0);
    chk("t6_reset_valid", 32'(valid_n), 32'd0);
    chk("t6_reset_data", 32'(data_n), 32'd0);
    #1 resetn = 1'b1;
    ready_n = 1'b1;
    repeat (2 * BIT_CLK) @(posedge clk);
    p0 = n_pops;
    send_frame(2, 8'h7E, 1'b0, 1'b1, 1'b1);
    chk("t6_post_reset_pops", 32'(n_pops - p0), 32'd1);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
